// File: rtl/fam_lsu_pipe.sv
// Execute/memory stage register: captures one instruction per cycle, runs loads/stores over a
// req/ack handshake with timeout, and drives the writeback bus. Option macro: FAM_LSU_MISALIGN_TRAP_EN.
module fam_lsu_pipe #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_num,
  input  logic [31:0]       in_pc,
  input  logic [ADDR_W-1:0] in_aluout,
  input  logic [31:0]       in_wdata,
  input  logic              in_dmwe,
  input  logic              in_dmsign,
  input  logic [1:0]        in_dmwidth,
  input  logic [1:0]        in_rfwsrc,
  input  logic              in_rfwe,
  input  logic [4:0]        in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [38:0]       rfw,
  output logic              num_out,
  output logic              busy,
  output logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_width;
  logic              r_sign, r_dmwe, r_rfwe, r_num;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic [TO_W-1:0]   r_to_cnt;
  logic [38:0]       r_rfw, r_pend;
  logic              r_num_out, r_mem_err;

  logic        w_accept, w_is_mem, w_trap, w_to_hit;
  logic [31:0] w_alu_data, w_shift, w_load;
  logic [38:0] w_mem_result;
  logic [3:0]  w_be;
  logic [31:0] w_lane;

  assign w_accept = in_valid && in_ready;
  assign w_is_mem = in_dmwe || (in_rfwsrc == 2'd2);
  assign w_to_hit = (r_state == S_ACCESS) && !mem_ack && (r_to_cnt == TO_W'(TIMEOUT - 1));

`ifdef FAM_LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (in_dmwidth == 2'd1) ? in_aluout[0] :
                      (in_dmwidth == 2'd0) ? 1'b0 : (in_aluout[1:0] != 2'b00);
  assign w_trap     = w_is_mem && w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  assign w_alu_data = (in_rfwsrc == 2'd1) ? 32'(in_aluout) :
                      (in_rfwsrc == 2'd3) ? in_pc + 32'd4 : 32'd0;

  // Load data is lane-shifted down first, then extended by access width.
  assign w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    case (r_width)
      2'd0:    w_load = {{24{r_sign & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end
  assign w_mem_result = {r_rfwe && !r_dmwe, 1'b1, r_rd, r_dmwe ? 32'd0 : w_load};

  always_comb begin
    case (r_width)
      2'd0:    begin w_be = 4'b0001 << r_addr[1:0]; w_lane = {4{r_wdata[7:0]}};  end
      2'd1:    begin w_be = 4'b0011 << r_addr[1:0]; w_lane = {2{r_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                w_lane = r_wdata;            end
    endcase
  end

  // NOTE: non-blocking assignments in every clocked process so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves the output unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_is_mem && !w_trap) w_state_nxt = S_ACCESS;
      S_ACCESS: if (mem_ack)       w_state_nxt = stop ? S_HOLD : S_IDLE;
                else if (w_to_hit) w_state_nxt = S_IDLE;
      S_HOLD:   if (!stop)         w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Memory-side outputs are gated by state so reset clears them without a clock.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !stop;
    busy      = (r_state != S_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (r_state == S_ACCESS) begin
      mem_req   = 1'b1;
      mem_we    = r_dmwe;
      mem_be    = w_be;
      mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = w_lane;
    end
  end

  assign rfw     = r_rfw;
  assign num_out = r_num_out;
  assign mem_err = r_mem_err;

  // NOTE: the captured operand registers are reset too, so nothing reaches the bus as X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_width   <= 2'd0;
      r_sign    <= 1'b0;
      r_dmwe    <= 1'b0;
      r_rfwe    <= 1'b0;
      r_num     <= 1'b0;
      r_wdata   <= 32'd0;
      r_rd      <= 5'd0;
      r_to_cnt  <= '0;
      r_rfw     <= 39'd0;
      r_pend    <= 39'd0;
      r_num_out <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_to_hit || (w_accept && w_trap);
      if (w_accept && w_is_mem) begin
        r_addr   <= in_aluout;
        r_width  <= in_dmwidth;
        r_sign   <= in_dmsign;
        r_dmwe   <= in_dmwe;
        r_rfwe   <= in_rfwe;
        r_num    <= in_num;
        r_wdata  <= in_wdata;
        r_rd     <= in_rd;
        r_to_cnt <= '0;
      end else if (r_state == S_ACCESS && !mem_ack) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (r_state == S_ACCESS && mem_ack && stop) r_pend <= w_mem_result;
      if (!stop) begin
        case (r_state)
          S_IDLE:
            if (w_accept && !w_is_mem) begin
              r_rfw     <= {in_rfwe, 1'b1, in_rd, w_alu_data};
              r_num_out <= in_num;
            end else if (w_accept && w_trap) begin
              r_rfw     <= {1'b0, 1'b1, in_rd, 32'd0};
              r_num_out <= in_num;
            end else begin
              r_rfw[38] <= 1'b0;
            end
          S_ACCESS:
            if (mem_ack) begin
              r_rfw     <= w_mem_result;
              r_num_out <= r_num;
            end else if (w_to_hit) begin
              r_rfw     <= {1'b0, 1'b1, r_rd, 32'd0};
              r_num_out <= r_num;
            end else begin
              r_rfw[38] <= 1'b0;
            end
          S_HOLD: begin
            r_rfw     <= r_pend;
            r_num_out <= r_num;
          end
          default: r_rfw[38] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fam_lsu_pipe.sv
// Directed bench for fam_lsu_pipe with TIMEOUT=4: ALU writeback, loads, stores, stall/HOLD,
// timeout, misaligned access and asynchronous reset mid-access.
module tb_fam_lsu_pipe;

  logic        clk = 1'b0;
  logic        rst, stop, in_valid, in_ready, in_num;
  logic [31:0] in_pc, in_aluout, in_wdata;
  logic        in_dmwe, in_dmsign, in_rfwe;
  logic [1:0]  in_dmwidth, in_rfwsrc;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [38:0] rfw;
  logic        num_out, busy, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  fam_lsu_pipe #(.ADDR_W(32), .TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_pc(in_pc), .in_aluout(in_aluout), .in_wdata(in_wdata),
    .in_dmwe(in_dmwe), .in_dmsign(in_dmsign), .in_dmwidth(in_dmwidth),
    .in_rfwsrc(in_rfwsrc), .in_rfwe(in_rfwe), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rfw(rfw), .num_out(num_out), .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                          input logic we, input logic sgn, input logic [1:0] wid,
                          input logic [1:0] src, input logic rfwe, input logic [4:0] rd,
                          input logic num);
    in_valid = 1'b1; in_pc = pc; in_aluout = alu; in_wdata = wd; in_dmwe = we;
    in_dmsign = sgn; in_dmwidth = wid; in_rfwsrc = src; in_rfwe = rfwe; in_rd = rd; in_num = num;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stop = 1'b0; in_valid = 1'b0; in_num = 1'b0; in_pc = '0; in_aluout = '0;
    in_wdata = '0; in_dmwe = 1'b0; in_dmsign = 1'b0; in_dmwidth = 2'd0; in_rfwsrc = 2'd0;
    in_rfwe = 1'b0; in_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rfw", rfw, 39'd0);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_err", mem_err, 0);
    check("rst_num", num_out, 0);
    check("rst_be", mem_be, 0);
    rst = 1'b0;
    @(negedge clk);

    // ALU result writeback, then held by stop for two cycles
    drive_op(32'h0, 32'h1234, 32'h0, 0, 0, 2'd2, 2'd1, 1, 5'd5, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("alu_rfw", rfw, {1'b1, 1'b1, 5'd5, 32'h1234});
    check("alu_num", num_out, 1);
    check("alu_req", mem_req, 0);
    stop = 1'b1;
    #1 check("stop_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stop_hold", rfw, {1'b1, 1'b1, 5'd5, 32'h1234});
    end
    stop = 1'b0;
    @(negedge clk);
    check("bubble_we", rfw[38], 0);

    // pc+4 writeback
    drive_op(32'h100, 32'h0, 32'h0, 0, 0, 2'd2, 2'd3, 1, 5'd7, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("pc4_rfw", rfw, {1'b1, 1'b1, 5'd7, 32'h104});
    check("pc4_num", num_out, 0);

    // lb at 0x103, ack in third request cycle
    drive_op(32'h200, 32'h103, 32'h0, 0, 1, 2'd0, 2'd2, 1, 5'd9, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lb_addr", mem_addr, 32'h100);
    check("lb_be", mem_be, 4'b1000);
    check("lb_we", mem_we, 0);
    check("lb_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("lb_req", mem_req, 1);
      check("lb_busy", busy, 1);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h8000_0000; end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("lb_req_done", mem_req, 0);
    check("lb_busy_done", busy, 0);
    check("lb_rfw", rfw, {1'b1, 1'b1, 5'd9, 32'hFFFF_FF80});
    check("lb_num", num_out, 1);

    // sh at 0x102, zero-wait ack
    drive_op(32'h0, 32'h102, 32'h0000_ABCD, 1, 0, 2'd1, 2'd0, 1, 5'd2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("sh_be", mem_be, 4'b1100);
    check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    check("sh_we", mem_we, 1);
    check("sh_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("sh_rfw_we", rfw[38], 0);
    check("sh_req_done", mem_req, 0);

    // lhu at 0x102, zero-wait
    drive_op(32'h0, 32'h102, 32'h0, 0, 0, 2'd1, 2'd2, 1, 5'd10, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lhu_be", mem_be, 4'b1100);
    mem_ack = 1'b1; mem_rdata = 32'h8001_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    check("lhu_rfw", rfw, {1'b1, 1'b1, 5'd10, 32'h0000_8001});

    // lw acked while stalled: HOLD for two cycles, then writeback
    drive_op(32'h0, 32'h200, 32'h0, 0, 0, 2'd2, 2'd2, 1, 5'd3, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lw_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; stop = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("hold_busy", busy, 1);
      check("hold_req", mem_req, 0);
      check("hold_rfw_we", rfw[38], 0);
      if (i == 1) stop = 1'b0;
      @(negedge clk);
    end
    check("hold_rfw", rfw, {1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF});
    check("hold_busy_done", busy, 0);
    check("hold_num", num_out, 0);

    // lw with no ack: timeout after 4 request cycles
    drive_op(32'h0, 32'h300, 32'h0, 0, 0, 2'd2, 2'd2, 1, 5'd4, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_req", mem_req, 1);
      check("to_err_low", mem_err, 0);
      @(negedge clk);
    end
    check("to_req_drop", mem_req, 0);
    check("to_err", mem_err, 1);
    check("to_rfw_we", rfw[38], 0);
    check("to_ready", in_ready, 1);
    @(negedge clk);
    check("to_err_pulse", mem_err, 0);

    // ack in the timeout cycle wins
    drive_op(32'h0, 32'h304, 32'h0, 0, 0, 2'd2, 2'd2, 1, 5'd6, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("race_req", mem_req, 1);
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h1122_3344; end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("race_err", mem_err, 0);
    check("race_rfw", rfw, {1'b1, 1'b1, 5'd6, 32'h1122_3344});

    // misaligned lw at 0x101: no fault, full byte enables
    drive_op(32'h0, 32'h101, 32'h0, 0, 0, 2'd2, 2'd2, 1, 5'd8, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("mis_req", mem_req, 1);
    check("mis_be", mem_be, 4'b1111);
    check("mis_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
    @(negedge clk);
    mem_ack = 1'b0;
    check("mis_err", mem_err, 0);
    check("mis_rfw", rfw, {1'b1, 1'b1, 5'd8, 32'h00AA_BBCC});

    // asynchronous reset during ACCESS
    drive_op(32'h0, 32'h400, 32'h0, 0, 0, 2'd2, 2'd2, 1, 5'd1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_req_pre", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_req", mem_req, 0);
    check("ar_busy", busy, 0);
    check("ar_rfw", rfw, 39'd0);
    check("ar_be", mem_be, 0);
    check("ar_num", num_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_ready", in_ready, 1);
    check("ar_req_after", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
